// File: rtl/imm_extract_pipe_if.sv
// Handshake bundle between the opcode sub-decoder and the immediate extractor.
// The master drives instructions in and accepts results; the slave is the extractor.
interface imm_extract_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [2:0]      in_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_err;

  modport master (
    output in_valid, in_instr, in_sel, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_sel, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_extract_pipe.sv
// Two-stage RV32I immediate extractor: stage 1 captures instr/sel, stage 2 registers
// the sign-extended immediate. Saturating count of illegal selects for debug.
module imm_extract_pipe #(
  parameter int XLEN     = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_extract_pipe_if.slave   bus,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_S = 3'b001,
    SEL_B = 3'b010,
    SEL_U = 3'b011,
    SEL_J = 3'b100
  } imm_sel_e;

  logic            s1_valid;
  logic [XLEN-1:0] s1_instr;
  logic [2:0]      s1_sel;
  logic            s2_valid;
  logic [XLEN-1:0] s2_imm;
  logic            s2_err;

  logic            s2_load;
  logic            s1_load;
  logic            in_xfer;
  logic            in_illegal;
  logic [XLEN-1:0] imm_nxt;
  logic            err_nxt;

  assign s2_load    = !s2_valid || bus.out_ready;
  assign s1_load    = !s1_valid || s2_load;
  assign in_xfer    = bus.in_valid && s1_load;
  assign in_illegal = (bus.in_sel > SEL_J);

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_imm   = s2_imm;
  assign bus.out_err   = s2_err;

  always_comb begin
    imm_nxt = '0;
    err_nxt = 1'b0;
    case (s1_sel)
      SEL_I:   imm_nxt = {{20{s1_instr[31]}}, s1_instr[31:20]};
      SEL_S:   imm_nxt = {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
      SEL_B:   imm_nxt = {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                          s1_instr[30:25], s1_instr[11:8], 1'b0};
      SEL_U:   imm_nxt = {s1_instr[31:12], 12'h000};
      SEL_J:   imm_nxt = {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                          s1_instr[20], s1_instr[30:21], 1'b0};
      default: err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_sel   <= '0;
      s2_valid <= 1'b0;
      s2_imm   <= '0;
      s2_err   <= 1'b0;
      err_cnt  <= '0;
    end else if (flush) begin
      // Flush kills both stages but leaves the debug counter and stale result data alone
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_imm <= imm_nxt;
          s2_err <= err_nxt;
        end
      end
      if (s1_load) begin
        s1_valid <= in_xfer;
        if (in_xfer) begin
          s1_instr <= bus.in_instr;
          s1_sel   <= bus.in_sel;
        end
      end
      if (in_xfer && in_illegal && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_extract_pipe.sv
// Directed plus randomised bench for imm_extract_pipe with a queue-based reference model.
module tb_imm_extract_pipe;

  typedef struct {
    logic [31:0] imm;
    logic        err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] err_cnt;

  imm_extract_pipe_if #(.XLEN(32)) ifc ();

  imm_extract_pipe #(.XLEN(32), .ERRCNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (ifc),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned bad;
  int unsigned ecnt_m;
  int unsigned n_in;
  int unsigned n_out;
  exp_t        q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Immediate built from field positions with plain shifts and masks
  function automatic exp_t ref_model(input logic [31:0] w, input logic [2:0] s);
    exp_t e;
    logic signed [31:0] sw;
    logic [31:0] hi;
    sw    = $signed(w);
    e.imm = '0;
    e.err = 1'b0;
    case (s)
      3'd0: e.imm = sw >>> 20;
      3'd1: begin
        hi    = sw >>> 25;
        e.imm = (hi << 5) | ((w >> 7) & 32'h1F);
      end
      3'd2: begin
        e.imm = (((w >> 8) & 32'hF) << 1) | (((w >> 25) & 32'h3F) << 5)
              | (((w >> 7) & 32'h1) << 11);
        if (w[31]) e.imm = e.imm | 32'hFFFFF000;
      end
      3'd3: e.imm = w & 32'hFFFFF000;
      3'd4: begin
        e.imm = (((w >> 21) & 32'h3FF) << 1) | (((w >> 20) & 32'h1) << 11)
              | (((w >> 12) & 32'hFF) << 12);
        if (w[31]) e.imm = e.imm | 32'hFFF00000;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: account transfers seen before the edge, then check after it
  task automatic cycle();
    logic        hold;
    logic [31:0] h_imm;
    logic        h_err;
    exp_t        e;
    #1;
    hold  = (ifc.out_valid === 1'b1) && !ifc.out_ready && rst_n && !flush;
    h_imm = ifc.out_imm;
    h_err = ifc.out_err;
    if (!rst_n) begin
      q.delete();
      ecnt_m = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ifc.out_valid === 1'b1 && ifc.out_ready) begin
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL spurious_out got=%h exp=none", ifc.out_imm);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_imm", ifc.out_imm, e.imm);
          chk("out_err", ifc.out_err, e.err);
          n_out++;
        end
      end
      if (ifc.in_valid && ifc.in_ready === 1'b1) begin
        q.push_back(ref_model(ifc.in_instr, ifc.in_sel));
        n_in++;
        if (ifc.in_sel > 3'd4 && ecnt_m < 255) ecnt_m++;
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", ifc.out_valid, 1);
      chk("hold_imm", ifc.out_imm, h_imm);
      chk("hold_err", ifc.out_err, h_err);
    end
    chk("err_cnt", err_cnt, ecnt_m);
  endtask

  task automatic drain();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 50 && (q.size() != 0 || ifc.out_valid !== 1'b0); k++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  logic [31:0] lg_ins[5];
  logic [2:0]  lg_sel[5];
  logic [31:0] lg_exp[5];
  int unsigned base_in;
  int unsigned base_out;

  initial begin
    total = 0; bad = 0; ecnt_m = 0; n_in = 0; n_out = 0;
    lg_ins = '{32'hFFF00093, 32'hFE112E23, 32'h80000063, 32'h123450B7, 32'h800000EF};
    lg_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    lg_exp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFF000, 32'h12345000, 32'hFFF00000};

    rst_n = 1'b0; flush = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.in_sel = '0; ifc.out_ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_imm", ifc.out_imm, 0);
    chk("rst_out_err", ifc.out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", ifc.in_ready, 1);

    // Legal formats back-to-back
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      ifc.in_valid = (c < 5);
      if (c < 5) begin
        ifc.in_instr = lg_ins[c];
        ifc.in_sel   = lg_sel[c];
      end
      cycle();
      chk("lat_valid", ifc.out_valid, (c >= 1 && c <= 5));
      if (c >= 1 && c <= 5) begin
        chk("legal_imm", ifc.out_imm, lg_exp[c-1]);
        chk("legal_err", ifc.out_err, 0);
      end
    end

    // Illegal selects, then saturation
    for (int s = 5; s < 8; s++) begin
      ifc.in_valid = 1'b1;
      ifc.in_instr = $urandom;
      ifc.in_sel   = 3'(s);
      cycle();
    end
    drain();
    chk("illegal_cnt3", err_cnt, 3);
    for (int k = 0; k < 300; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_instr = $urandom;
      ifc.in_sel   = 3'($urandom_range(5, 7));
      cycle();
    end
    drain();
    chk("sat_cnt", err_cnt, 255);
    ifc.in_valid = 1'b1; ifc.in_sel = 3'd7;
    cycle();
    drain();
    chk("sat_hold", err_cnt, 255);

    // Backpressure: two accepted, third refused until drained
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_instr = $urandom;
      ifc.in_sel   = 3'(k + 1);
      #1;
      chk("bp_accept", ifc.in_ready, 1);
      cycle();
    end
    ifc.in_instr = 32'h800000EF; ifc.in_sel = 3'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_refuse", ifc.in_ready, 0);
      cycle();
    end
    ifc.out_ready = 1'b1;
    cycle();
    base_out = n_out;
    drain();
    chk("bp_count", n_out - base_out, 2);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) begin
      ifc.in_valid = 1'b1; ifc.in_instr = $urandom; ifc.in_sel = 3'($urandom_range(0, 7));
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; ifc.in_valid = 1'b0;
    chk("mrst_valid", ifc.out_valid, 0);
    chk("mrst_cnt", err_cnt, 0);
    chk("mrst_ready", ifc.in_ready, 1);
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h123450B7; ifc.in_sel = 3'd3;
    cycle();
    ifc.in_valid = 1'b0;
    chk("mrst_lat1", ifc.out_valid, 0);
    cycle();
    chk("mrst_lat2", ifc.out_valid, 1);
    chk("mrst_imm", ifc.out_imm, 32'h12345000);
    drain();

    // Flush with two buffered and one offered
    ifc.out_ready = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_instr = $urandom; ifc.in_sel = 3'd6;
    cycle();
    ifc.in_instr = $urandom; ifc.in_sel = 3'd0;
    cycle();
    ifc.in_instr = $urandom; ifc.in_sel = 3'd5;
    flush = 1'b1;
    cycle();
    flush = 1'b0; ifc.in_valid = 1'b0;
    chk("flush_valid", ifc.out_valid, 0);
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("flush_quiet", ifc.out_valid, 0);
    end
    chk("flush_cnt", err_cnt, 1);

    // Randomised valid/ready
    base_in = n_in; base_out = n_out;
    for (int k = 0; k < 20000 && (n_in - base_in) < 1000; k++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.in_instr  = $urandom;
      ifc.in_sel    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
                                                  : 3'($urandom_range(0, 4));
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      if ((n_in - base_in) == 999) ifc.in_valid = ifc.in_valid;
      cycle();
    end
    ifc.in_valid = 1'b0;
    drain();
    chk("rand_in", n_in - base_in, 1000);
    chk("rand_out", n_out - base_out, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
